pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arbiter.sv | 137 +++++++++++++
 tb/tb_pci_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: fixed-priority or round-robin grant of the bus with
// turnaround, grant timeout and optional parking.
module pci_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int RR_MODE   = 0,
  parameter int TIMEOUT   = 16,
  parameter int PARK_EN   = 0,
  parameter int PARK_IDX  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] gnt_idx,
  output logic                         gnt_valid
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] PARK = IW'(PARK_IDX);
  localparam logic [IW-1:0] LAST = IW'(N_MASTERS - 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);

  typedef enum logic [1:0] {
    IDLE, GRANTED, BUSY, TURN
  } state_t;

  state_t               state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        lastOwner;
  logic [CW-1:0]        toCnt;
  logic [N_MASTERS-1:0] excl;

  logic [N_MASTERS-1:0] reqVec;
  logic                 anyReq;
  logic                 busIdle;
  logic                 parkNow;
  logic                 winFound;
  logic [IW-1:0]        winIdx;
  logic [IW-1:0]        srch;

  assign reqVec  = ~req_n & ~excl;
  assign anyReq  = |(~req_n);
  assign busIdle = frame_n & irdy_n;
  assign parkNow = (PARK_EN != 0) && busIdle && !anyReq;

  // Fixed priority is a round-robin search that always starts after the top index.
  always_comb begin
    srch     = (RR_MODE != 0) ? lastOwner : LAST;
    winFound = 1'b0;
    winIdx   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      srch = (srch == LAST) ? '0 : srch + IW'(1);
      if (!winFound && reqVec[srch]) begin
        winFound = 1'b1;
        winIdx   = srch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      lastOwner <= LAST;
      toCnt     <= '0;
      excl      <= '0;
      gnt_n     <= '1;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, TURN: begin
          if (anyReq) excl <= '0;
          if (state == IDLE && gnt_valid) begin
            // Parked: the parked master may start without requesting.
            if (!frame_n) begin
              state <= BUSY;
            end else if (anyReq) begin
              if (winFound && winIdx == PARK) begin
                state <= GRANTED;
                toCnt <= '0;
              end else begin
                state     <= TURN;
                gnt_n     <= '1;
                gnt_idx   <= '0;
                gnt_valid <= 1'b0;
              end
            end
          end else if (winFound) begin
            state     <= GRANTED;
            owner     <= winIdx;
            toCnt     <= '0;
            gnt_n     <= ~(ONE << winIdx);
            gnt_idx   <= winIdx;
            gnt_valid <= 1'b1;
          end else if (parkNow) begin
            state     <= IDLE;
            owner     <= PARK;
            gnt_n     <= ~(ONE << PARK);
            gnt_idx   <= PARK;
            gnt_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GRANTED: begin
          if (!frame_n) begin
            state     <= BUSY;
            lastOwner <= owner;
          end else if (req_n[owner] || toCnt == TLIM) begin
            if (!req_n[owner]) excl <= ONE << owner;
            state     <= TURN;
            gnt_n     <= '1;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end else if (toCnt != {CW{1'b1}}) begin
            toCnt <= toCnt + CW'(1);
          end
        end
        BUSY: begin
          if (frame_n) begin
            gnt_n     <= '1;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end
          if (busIdle) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter: fixed, round-robin and parking
// instances share one set of bus inputs.
module tb_pci_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_n;
  logic       frame_n;
  logic       irdy_n;

  logic [2:0] fixGnt, rrGnt, parkGnt;
  logic [1:0] fixIdx, rrIdx, parkIdx;
  logic       fixVal, rrVal, parkVal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pci_arbiter #(.N_MASTERS(3), .RR_MODE(0)) uFix (
    .clk(clk), .rst(rst), .req_n(req_n), .frame_n(frame_n),
    .irdy_n(irdy_n), .gnt_n(fixGnt), .gnt_idx(fixIdx),
    .gnt_valid(fixVal)
  );

  pci_arbiter #(.N_MASTERS(3), .RR_MODE(1)) uRr (
    .clk(clk), .rst(rst), .req_n(req_n), .frame_n(frame_n),
    .irdy_n(irdy_n), .gnt_n(rrGnt), .gnt_idx(rrIdx),
    .gnt_valid(rrVal)
  );

  pci_arbiter #(.N_MASTERS(3), .PARK_EN(1), .PARK_IDX(2)) uPark (
    .clk(clk), .rst(rst), .req_n(req_n), .frame_n(frame_n),
    .irdy_n(irdy_n), .gnt_n(parkGnt), .gnt_idx(parkIdx),
    .gnt_valid(parkVal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_n = 3'b111; frame_n = 1'b1; irdy_n = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_n = 3'b111; frame_n = 1'b1; irdy_n = 1'b1;
    step(); step();
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL reset_gnt got %b want 111", fixGnt); end
    checks++; if (fixVal !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fixVal); end
    checks++; if (fixIdx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", fixIdx); end
    checks++; if (parkGnt !== 3'b111) begin errors++; $display("FAIL reset_park got %b want 111", parkGnt); end
    req_n = 3'b000;
    step();
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL reset_req got %b want 111", fixGnt); end
    rst = 1'b0;
    step();
    checks++; if (fixGnt !== 3'b110) begin errors++; $display("FAIL first_arb got %b want 110", fixGnt); end
  endtask

  task automatic test_fixed();
    do_reset();
    req_n = 3'b000;
    step();
    checks++; if (fixGnt !== 3'b110) begin errors++; $display("FAIL fix_all gnt got %b want 110", fixGnt); end
    checks++; if (fixIdx !== 2'd0) begin errors++; $display("FAIL fix_all idx got %0d want 0", fixIdx); end
    checks++; if (fixVal !== 1'b1) begin errors++; $display("FAIL fix_all valid got %b want 1", fixVal); end
    req_n = 3'b111;
    step();
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL fix_release got %b want 111", fixGnt); end
    step();
    req_n = 3'b001;
    step();
    checks++; if (fixGnt !== 3'b101) begin errors++; $display("FAIL fix_12 gnt got %b want 101", fixGnt); end
    checks++; if (fixIdx !== 2'd1) begin errors++; $display("FAIL fix_12 idx got %0d want 1", fixIdx); end
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    logic [2:0] one;
    logic [2:0] expG;
    do_reset();
    req_n = 3'b000;
    step();
    for (int k = 0; k < 4; k++) begin
      one  = 3'b001;
      expG = ~(one << order[k]);
      checks++; if (rrGnt !== expG) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, rrGnt, expG); end
      checks++; if (rrIdx !== 2'(order[k])) begin errors++; $display("FAIL rr_idx%0d got %0d want %0d", k, rrIdx, order[k]); end
      frame_n = 1'b0; irdy_n = 1'b0;
      step();
      checks++; if (rrGnt !== expG) begin errors++; $display("FAIL rr_start%0d got %b want %b", k, rrGnt, expG); end
      frame_n = 1'b1;
      step();
      checks++; if (rrGnt !== 3'b111) begin errors++; $display("FAIL rr_turn%0d got %b want 111", k, rrGnt); end
      irdy_n = 1'b1;
      step();
      step();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_n = 3'b101;
    step();
    for (int i = 0; i < 16; i++) begin
      checks++; if (fixGnt !== 3'b101) begin errors++; $display("FAIL to_hold%0d got %b want 101", i, fixGnt); end
      step();
    end
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL to_turn got %b want 111", fixGnt); end
    req_n = 3'b001;
    step();
    checks++; if (fixGnt !== 3'b011) begin errors++; $display("FAIL to_excl got %b want 011", fixGnt); end
    checks++; if (fixIdx !== 2'd2) begin errors++; $display("FAIL to_excl_idx got %0d want 2", fixIdx); end
    req_n = 3'b101;
    step();
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL to_drop got %b want 111", fixGnt); end
    step();
    checks++; if (fixGnt !== 3'b101) begin errors++; $display("FAIL to_once got %b want 101", fixGnt); end
  endtask

  task automatic test_park();
    do_reset();
    step();
    checks++; if (parkGnt !== 3'b011) begin errors++; $display("FAIL park_idle got %b want 011", parkGnt); end
    checks++; if (parkIdx !== 2'd2) begin errors++; $display("FAIL park_idx got %0d want 2", parkIdx); end
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL nopark_idle got %b want 111", fixGnt); end
    req_n = 3'b110;
    step();
    checks++; if (parkGnt !== 3'b111) begin errors++; $display("FAIL park_turn got %b want 111", parkGnt); end
    step();
    checks++; if (parkGnt !== 3'b110) begin errors++; $display("FAIL park_m0 got %b want 110", parkGnt); end
    req_n = 3'b111;
    step(); step();
    checks++; if (parkGnt !== 3'b011) begin errors++; $display("FAIL park_again got %b want 011", parkGnt); end
    req_n = 3'b011;
    step();
    checks++; if (parkGnt !== 3'b011) begin errors++; $display("FAIL park_self got %b want 011", parkGnt); end
    req_n = 3'b111;
    step();
    checks++; if (parkGnt !== 3'b111) begin errors++; $display("FAIL park_self_drop got %b want 111", parkGnt); end
    step();
    checks++; if (parkGnt !== 3'b011) begin errors++; $display("FAIL park_back got %b want 011", parkGnt); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    req_n = 3'b101;
    step();
    frame_n = 1'b0; irdy_n = 1'b0;
    step();
    checks++; if (fixGnt !== 3'b101) begin errors++; $display("FAIL rb_busy got %b want 101", fixGnt); end
    rst = 1'b1;
    step();
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL rb_gnt got %b want 111", fixGnt); end
    checks++; if (fixVal !== 1'b0) begin errors++; $display("FAIL rb_valid got %b want 0", fixVal); end
    rst = 1'b0; req_n = 3'b110; frame_n = 1'b1; irdy_n = 1'b1;
    step();
    checks++; if (fixGnt !== 3'b110) begin errors++; $display("FAIL rb_regrant got %b want 110", fixGnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_n = 3'b101;
    step();
    frame_n = 1'b0; irdy_n = 1'b0; req_n = 3'b100;
    step();
    checks++; if (fixGnt !== 3'b101) begin errors++; $display("FAIL b2b_hold1 got %b want 101", fixGnt); end
    step();
    checks++; if (fixGnt !== 3'b101) begin errors++; $display("FAIL b2b_hold2 got %b want 101", fixGnt); end
    frame_n = 1'b1;
    step();
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL b2b_hidden got %b want 111", fixGnt); end
    irdy_n = 1'b1;
    step();
    checks++; if (fixGnt !== 3'b111) begin errors++; $display("FAIL b2b_idle got %b want 111", fixGnt); end
    step();
    checks++; if (fixGnt !== 3'b110) begin errors++; $display("FAIL b2b_m0 got %b want 110", fixGnt); end
    checks++; if (fixIdx !== 2'd0) begin errors++; $display("FAIL b2b_idx got %0d want 0", fixIdx); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout();
    test_park();
    test_reset_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
